// File: rtl/cp0_regfile_pkg.sv
// cp0_regfile_pkg
//   Shared definitions for the CP0 register file: register numbers, ExcCode
//   values, Status/Cause bit positions, write masks and reset values.
package cp0_regfile_pkg;

    // Register numbers (mfc0/mtc0 rd field)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status / Cause bit positions
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_BD   = 31;

    // Software-writable bits and fixed values
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    // Value an mtc0 to Status leaves in the register (BEV always reads 1).
    function automatic logic [31:0] status_masked(input logic [31:0] wdata);
        return STATUS_RESET | (wdata & STATUS_WMASK);
    endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// cp0_timer
//   Count/Compare timer. Count advances once every COUNT_DIV core clocks;
//   TI is raised when an increment makes Count equal Compare and is cleared
//   by any Compare write.
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   count_we_i      load Count from wdata_i (also restarts the prescaler)
//   compare_we_i    load Compare from wdata_i (also clears TI)
//   wdata_i         write data shared by both registers
//   count_o         current Count
//   compare_o       current Compare
//   ti_o            timer interrupt flag
module cp0_timer
    import cp0_regfile_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    // Legal divisors are 1 and 2, so one prescaler bit is enough.
    localparam logic PRE_LAST = 1'(COUNT_DIV - 1);

    logic        pre_q,     pre_d;
    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q,      ti_d;
    logic        tick;
    logic [31:0] count_inc;

    assign tick      = (pre_q == PRE_LAST);
    assign count_inc = count_q + 32'd1;   // wraps FFFF_FFFF -> 0 silently

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        pre_d     = tick ? 1'b0 : pre_q + 1'b1;
        count_d   = tick ? count_inc : count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        if (count_we_i) begin
            // A software load replaces this cycle's increment entirely.
            count_d = wdata_i;
            pre_d   = 1'b0;
        end else if (tick && (count_inc == compare_q)) begin
            ti_d = 1'b1;
        end

        // Clear wins over a coincident match.
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q     <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile
//   Coprocessor-0 register file: mfc0 read port (ID), mtc0 write port (WB),
//   exception entry / ERET updates, interrupt request and Count/Compare timer.
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   read_addr/read_data mfc0 select and combinational data (write-forwarded)
//   write_en/addr/data  mtc0 commit from WB
//   int_hw              level-sensitive hardware interrupt lines
//   exc_*               exception commit and its attributes
//   eret_en             ERET commit
//   int_req             pending enabled interrupt
//   flush/flush_target  pipeline redirect on exception or ERET
//   status_out, cause_out, epc_out  current register values
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VALUE = 32'h0001_8000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  read_addr,
    output logic [31:0] read_data,
    input  logic        write_en,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    input  logic [5:0]  int_hw,
    input  logic        exc_en,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_en,
    output logic        int_req,
    output logic        flush,
    output logic [31:0] flush_target,
    output logic [31:0] status_out,
    output logic [31:0] cause_out,
    output logic [31:0] epc_out
);

    logic [7:0]  im_q,       im_d;
    logic        exl_q,      exl_d;
    logic        ie_q,       ie_d;
    logic        bd_q,       bd_d;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q,    ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q,      epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [31:0] status, cause, count, compare;
    logic        ti, wr_ok;

    // The mtc0 in WB is being flushed whenever an exception or ERET commits.
    assign wr_ok = write_en & ~exc_en & ~eret_en;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (wr_ok && (write_addr == CP0_COUNT)),
        .compare_we_i (wr_ok && (write_addr == CP0_COMPARE)),
        .wdata_i      (write_data),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    assign status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    // IP7 combines the sampled line with TI so it rises together with TI.
    assign cause  = {bd_q, ti, 14'b0, ip_hw_q[5] | ti, ip_hw_q[4:0],
                     ip_sw_q, 1'b0, exc_code_q, 2'b0};

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (exc_en) begin
            // A nested exception keeps the original return point.
            if (!exl_q) begin
                epc_d = exc_delay_slot ? exc_pc - 32'd4 : exc_pc;
                bd_d  = exc_delay_slot;
            end
            exl_d      = 1'b1;
            exc_code_d = exc_code;
            if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
                badvaddr_d = exc_badvaddr;
        end else if (eret_en) begin
            exl_d = 1'b0;
        end else if (write_en) begin
            case (write_addr)
                CP0_STATUS: begin
                    im_d  = write_data[15:8];
                    exl_d = write_data[STATUS_EXL];
                    ie_d  = write_data[STATUS_IE];
                end
                CP0_CAUSE: ip_sw_d = write_data[9:8];
                CP0_EPC:   epc_d   = write_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_hw_q    <= int_hw;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // mfc0 read: register mux, then same-cycle forward of a committing mtc0.
    always_comb begin
        read_data = '0;
        case (read_addr)
            CP0_BADVADDR: read_data = badvaddr_q;
            CP0_COUNT:    read_data = count;
            CP0_COMPARE:  read_data = compare;
            CP0_STATUS:   read_data = status;
            CP0_CAUSE:    read_data = cause;
            CP0_EPC:      read_data = epc_q;
            CP0_PRID:     read_data = PRID_VALUE;
            default:      read_data = '0;
        endcase
        if (wr_ok && (write_addr == read_addr)) begin
            case (write_addr)
                CP0_STATUS:  read_data = status_masked(write_data);
                CP0_CAUSE:   read_data = (cause & ~CAUSE_WMASK) | (write_data & CAUSE_WMASK);
                CP0_EPC,
                CP0_COUNT,
                CP0_COMPARE: read_data = write_data;
                default: ;
            endcase
        end
    end

    assign int_req      = (|(cause[15:8] & im_q)) & ie_q & ~exl_q;
    assign flush        = exc_en | eret_en;
    // An EPC write alongside ERET is discarded, so pre-edge EPC is final here.
    assign flush_target = exc_en ? EXC_VECTOR : epc_q;
    assign status_out   = status;
    assign cause_out    = cause;
    assign epc_out      = epc_q;

endmodule
